// File: rtl/uart_tx.sv
// AXI4-Stream to UART transmitter: start bit, LSB-first data, optional parity, one stop bit.
// Define UART_TX_PARITY_EN to add the parity_odd input and a parity bit after the data bits.
module uart_tx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] input_axis_tdata,
  input  logic                  input_axis_tvalid,
  output logic                  input_axis_tready,
  output logic                  txd,
  output logic                  busy,
  input  logic [15:0]           prescale
`ifdef UART_TX_PARITY_EN
  ,
  input  logic                  parity_odd
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic [3:0] LAST_BIT = 4'(DATA_WIDTH - 1);

  state_t                state, state_next;
  logic [DATA_WIDTH-1:0] data_reg, data_next;
  logic [18:0]           period_reg, period_next;
  logic [18:0]           cnt, cnt_next;
  logic [3:0]            bit_cnt, bit_next;
  logic                  txd_next, tready_next, busy_next;
  logic [15:0]           prescale_eff;
`ifdef UART_TX_PARITY_EN
  logic                  parity_reg, parity_next;
`endif

  // A prescale of zero would give a zero-length bit; it is treated as one.
  assign prescale_eff = (prescale == 16'd0) ? 16'd1 : prescale;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      data_reg          <= '0;
      period_reg        <= '0;
      cnt               <= '0;
      bit_cnt           <= '0;
      txd               <= 1'b1;
      input_axis_tready <= 1'b0;
      busy              <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_reg        <= 1'b0;
`endif
    end else begin
      state             <= state_next;
      data_reg          <= data_next;
      period_reg        <= period_next;
      cnt               <= cnt_next;
      bit_cnt           <= bit_next;
      txd               <= txd_next;
      input_axis_tready <= tready_next;
      busy              <= busy_next;
`ifdef UART_TX_PARITY_EN
      parity_reg        <= parity_next;
`endif
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next  = state;
    data_next   = data_reg;
    period_next = period_reg;
    cnt_next    = cnt;
    bit_next    = bit_cnt;
    txd_next    = txd;
    tready_next = input_axis_tready;
    busy_next   = busy;
`ifdef UART_TX_PARITY_EN
    parity_next = parity_reg;
`endif

    case (state)
      IDLE: begin
        tready_next = 1'b1;
        busy_next   = 1'b0;
        txd_next    = 1'b1;
        if (input_axis_tvalid && input_axis_tready) begin
          data_next   = input_axis_tdata;
          period_next = {prescale_eff, 3'b000};
          cnt_next    = period_next - 19'd1;
          tready_next = 1'b0;
          busy_next   = 1'b1;
          txd_next    = 1'b0;
          state_next  = START;
`ifdef UART_TX_PARITY_EN
          parity_next = (^input_axis_tdata) ^ parity_odd;
`endif
        end
      end

      START: begin
        if (cnt == 19'd0) begin
          cnt_next   = period_reg - 19'd1;
          txd_next   = data_reg[0];
          data_next  = data_reg >> 1;
          bit_next   = 4'd0;
          state_next = DATA;
        end else begin
          cnt_next = cnt - 19'd1;
        end
      end

      DATA: begin
        if (cnt == 19'd0) begin
          cnt_next = period_reg - 19'd1;
          if (bit_cnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            txd_next   = parity_reg;
            state_next = PARITY;
`else
            txd_next   = 1'b1;
            state_next = STOP;
`endif
          end else begin
            bit_next  = bit_cnt + 4'd1;
            txd_next  = data_reg[0];
            data_next = data_reg >> 1;
          end
        end else begin
          cnt_next = cnt - 19'd1;
        end
      end

      PARITY: begin
        if (cnt == 19'd0) begin
          cnt_next   = period_reg - 19'd1;
          txd_next   = 1'b1;
          state_next = STOP;
        end else begin
          cnt_next = cnt - 19'd1;
        end
      end

      STOP: begin
        txd_next = 1'b1;
        if (cnt == 19'd0) begin
          tready_next = 1'b1;
          busy_next   = 1'b0;
          state_next  = IDLE;
        end else begin
          cnt_next = cnt - 19'd1;
        end
      end

      default: state_next = IDLE;
    endcase
  end

endmodule
